// File: rtl/rename_regfile.sv
// Architectural register file with a busy/tag rename table and a ring of rename-table
// checkpoints, so a mispredict restores the rename state of a branch instead of clearing it.
module rename_regfile #(
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int TAG_W    = 4,
  parameter int RD_PORTS = 2,
  parameter int CKPT_NUM = 4,
  localparam int AW = $clog2(REG_NUM),
  localparam int CW = $clog2(CKPT_NUM)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic [RD_PORTS*AW-1:0]       rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_value,
  output logic [RD_PORTS-1:0]          rd_busy,
  output logic [RD_PORTS*TAG_W-1:0]    rd_tag,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_rd,
  input  logic [TAG_W-1:0]             rsv_tag,
  input  logic                         commit_en,
  input  logic [AW-1:0]                commit_rd,
  input  logic [TAG_W-1:0]             commit_tag,
  input  logic [DATA_W-1:0]            commit_value,
  input  logic                         ckpt_take,
  output logic [CW-1:0]                ckpt_id,
  output logic                         ckpt_full,
  input  logic                         ckpt_free,
  input  logic                         recover_en,
  input  logic [CW-1:0]                recover_id,
  input  logic                         flush_all
);

  localparam logic [CW:0] FULL_CNT = (CW+1)'(CKPT_NUM);

  logic [DATA_W-1:0]  regs [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic [TAG_W-1:0]   tags [REG_NUM];

  logic [REG_NUM-1:0] ckpt_busy [CKPT_NUM];
  logic [TAG_W-1:0]   ckpt_tags [CKPT_NUM][REG_NUM];
  logic [CW-1:0]      head;
  logic [CW-1:0]      tail;
  logic [CW:0]        count;

  logic               commit_wr;
  logic               commit_live;
  logic               rec_commit_hit;
  logic               take_ok;
  logic               free_ok;
  logic [CW-1:0]      rec_count;
  logic [CKPT_NUM-1:0] slot_valid;

  logic [REG_NUM-1:0] busy_n;
  logic [TAG_W-1:0]   tags_n [REG_NUM];
  logic [CW-1:0]      head_n;
  logic [CW-1:0]      tail_n;
  logic [CW:0]        count_n;

  assign commit_wr      = commit_en && (commit_rd != '0);
  assign commit_live    = commit_wr && busy[commit_rd] && (tags[commit_rd] == commit_tag);
  assign rec_commit_hit = commit_wr && ckpt_busy[recover_id][commit_rd]
                          && (ckpt_tags[recover_id][commit_rd] == commit_tag);
  assign ckpt_full      = (count == FULL_CNT);
  assign ckpt_id        = tail;
  assign take_ok        = ckpt_take && !ckpt_full;
  assign free_ok        = ckpt_free && (count != '0);
  assign rec_count      = recover_id - head;

  // A slot is live when its distance from head is below the occupancy count.
  always_comb begin
    slot_valid = '0;
    for (int s = 0; s < CKPT_NUM; s++) begin
      slot_valid[s] = ({1'b0, CW'(s) - head} < count);
    end
  end

  // Next live rename table; checkpoints capture this post-update view.
  always_comb begin
    busy_n = busy;
    for (int r = 0; r < REG_NUM; r++) begin
      tags_n[r] = tags[r];
    end
    if (flush_all) begin
      busy_n = '0;
      for (int r = 0; r < REG_NUM; r++) begin
        tags_n[r] = '0;
      end
    end else if (recover_en) begin
      busy_n = ckpt_busy[recover_id];
      for (int r = 0; r < REG_NUM; r++) begin
        tags_n[r] = ckpt_tags[recover_id][r];
      end
      if (rec_commit_hit) begin
        busy_n[commit_rd] = 1'b0;
      end
    end else begin
      if (commit_live) begin
        busy_n[commit_rd] = 1'b0;
      end
      if (rsv_en && (rsv_rd != '0)) begin
        busy_n[rsv_rd] = 1'b1;
        tags_n[rsv_rd] = rsv_tag;
      end
    end
  end

  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    if (flush_all) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end else if (recover_en) begin
      tail_n  = recover_id;
      count_n = {1'b0, rec_count};
      if (ckpt_free && (rec_count != '0)) begin
        head_n  = head + 1'b1;
        count_n = {1'b0, rec_count} - 1'b1;
      end
    end else begin
      if (take_ok) begin
        tail_n = tail + 1'b1;
      end
      if (free_ok) begin
        head_n = head + 1'b1;
      end
      count_n = count + {{CW{1'b0}}, take_ok} - {{CW{1'b0}}, free_ok};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int r = 0; r < REG_NUM; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
    end else if (rdy_in) begin
      if (commit_wr) begin
        regs[commit_rd] <= commit_value;
      end
      busy  <= busy_n;
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      for (int r = 0; r < REG_NUM; r++) begin
        tags[r] <= tags_n[r];
      end
    end
  end

  // Slot storage needs no reset: a slot only becomes valid through a take that fills it.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in) begin
      for (int s = 0; s < CKPT_NUM; s++) begin
        if (slot_valid[s] && commit_wr && ckpt_busy[s][commit_rd]
            && (ckpt_tags[s][commit_rd] == commit_tag)) begin
          ckpt_busy[s][commit_rd] <= 1'b0;
        end
      end
      if (!flush_all && !recover_en && take_ok) begin
        ckpt_busy[tail] <= busy_n;
        for (int r = 0; r < REG_NUM; r++) begin
          ckpt_tags[tail][r] <= tags_n[r];
        end
      end
    end
  end

  // Same-cycle reserve is deliberately invisible; a matching commit is forwarded.
  always_comb begin
    rd_value = '0;
    rd_busy  = '0;
    rd_tag   = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rd_addr[p*AW +: AW] != '0) begin
        if (commit_wr && (commit_rd == rd_addr[p*AW +: AW]) && busy[rd_addr[p*AW +: AW]]
            && (tags[rd_addr[p*AW +: AW]] == commit_tag)) begin
          rd_value[p*DATA_W +: DATA_W] = commit_value;
        end else if (busy[rd_addr[p*AW +: AW]]) begin
          rd_busy[p]                = 1'b1;
          rd_tag[p*TAG_W +: TAG_W]  = tags[rd_addr[p*AW +: AW]];
        end else begin
          rd_value[p*DATA_W +: DATA_W] = regs[rd_addr[p*AW +: AW]];
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: read expectations go through a scoreboard queue,
// checkpoint ring status is compared inline inside each scenario task.
module tb_rename_regfile;

  localparam int AW = 5;
  localparam int CW = 2;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in;
  logic [2*AW-1:0] rd_addr;
  logic [63:0]   rd_value;
  logic [1:0]    rd_busy;
  logic [7:0]    rd_tag;
  logic          rsv_en;
  logic [AW-1:0] rsv_rd;
  logic [3:0]    rsv_tag;
  logic          commit_en;
  logic [AW-1:0] commit_rd;
  logic [3:0]    commit_tag;
  logic [31:0]   commit_value;
  logic          ckpt_take;
  logic [CW-1:0] ckpt_id;
  logic          ckpt_full;
  logic          ckpt_free;
  logic          recover_en;
  logic [CW-1:0] recover_id;
  logic          flush_all;

  rename_regfile dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rd_addr(rd_addr), .rd_value(rd_value), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .rsv_en(rsv_en), .rsv_rd(rsv_rd), .rsv_tag(rsv_tag),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_value(commit_value),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_free(ckpt_free),
    .recover_en(recover_en), .recover_id(recover_id), .flush_all(flush_all)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string         name;
    logic [AW-1:0] addr;
    logic [31:0]   value;
    logic          busy;
    logic [3:0]    tag;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t e;
  int tests = 0;
  int fails = 0;

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; rd_addr = '0;
    rsv_en = 1'b0; rsv_rd = '0; rsv_tag = '0;
    commit_en = 1'b0; commit_rd = '0; commit_tag = '0; commit_value = '0;
    ckpt_take = 1'b0; ckpt_free = 1'b0; recover_en = 1'b0; recover_id = '0; flush_all = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
    idle();
  endtask

  task automatic expect_rd(input string name, input logic [AW-1:0] a, input logic [31:0] v,
                           input logic b, input logic [3:0] t);
    e.name = name; e.addr = a; e.value = v; e.busy = b; e.tag = t;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    idle();
    rst_in = 1'b1;
    step();
    rst_in = 1'b1;
    step();
    tests++;
    if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ckpt: got id=%0d full=%b, expected id=0 full=0", ckpt_id, ckpt_full);
    end
    expect_rd("reset_x5", 5, 0, 0, 0);
    expect_rd("reset_x31", 31, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
  endtask

  task automatic test_reserve_forward();
    rsv_en = 1; rsv_rd = 5; rsv_tag = 3;
    expect_rd("rsv_same_cycle_hidden", 5, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
    step();
    expect_rd("rsv_x5_busy", 5, 0, 1, 3);
    expect_rd("x0_zero", 0, 0, 0, 0);
    expect_rd("x4_untouched", 4, 0, 0, 0);
    rd_addr = '0;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
      if (e.name == "rsv_x5_busy") begin
        commit_en = 1; commit_rd = 5; commit_tag = 3; commit_value = 32'hDEAD;
        expect_rd("commit_forward", 5, 32'hDEAD, 0, 0);
      end
    end
    step();
    expect_rd("commit_written", 5, 32'hDEAD, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
  endtask

  task automatic test_stale_commit();
    rsv_en = 1; rsv_rd = 5; rsv_tag = 3;  step();
    rsv_en = 1; rsv_rd = 5; rsv_tag = 7;  step();
    commit_en = 1; commit_rd = 5; commit_tag = 3; commit_value = 1;
    expect_rd("stale_no_forward", 5, 0, 1, 7);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
    step();
    expect_rd("stale_still_busy", 5, 0, 1, 7);
    expect_rd("x5_commit_t7", 5, 0, 1, 7);
    // x6: commit and reserve of the same register in one cycle, the reserve wins
    rsv_en = 1; rsv_rd = 6; rsv_tag = 1;  step();
    commit_en = 1; commit_rd = 6; commit_tag = 1; commit_value = 32'h66;
    rsv_en = 1; rsv_rd = 6; rsv_tag = 2;
    expect_rd("x6_forward_vs_rsv", 6, 32'h66, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
    step();
    commit_en = 1; commit_rd = 5; commit_tag = 7; commit_value = 2;
    expect_rd("x5_forward_t7", 5, 2, 0, 0);
    expect_rd("x6_rsv_wins", 6, 0, 1, 2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
    step();
    commit_en = 1; commit_rd = 0; commit_value = 32'h5; rsv_en = 1; rsv_rd = 0; rsv_tag = 1;
    step();
    expect_rd("x5_retired", 5, 2, 0, 0);
    expect_rd("x0_ignores_writes", 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
  endtask

  task automatic test_ckpt_recover();
    rsv_en = 1; rsv_rd = 1; rsv_tag = 1;  step();
    tests++;
    if (ckpt_id !== 2'd0) begin
      fails++;
      $display("[TB] FAIL take_id: got %0d, expected 0", ckpt_id);
    end
    ckpt_take = 1;                        step();
    tests++;
    if (ckpt_id !== 2'd1) begin
      fails++;
      $display("[TB] FAIL take_advance: got %0d, expected 1", ckpt_id);
    end
    rsv_en = 1; rsv_rd = 1; rsv_tag = 2;  step();
    rsv_en = 1; rsv_rd = 2; rsv_tag = 4;  step();
    commit_en = 1; commit_rd = 1; commit_tag = 1; commit_value = 9; step();
    expect_rd("x1_still_t2", 1, 0, 1, 2);
    expect_rd("x2_busy_t4", 2, 0, 1, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
    recover_en = 1; recover_id = 0;       step();
    tests++;
    if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin
      fails++;
      $display("[TB] FAIL recover_ptr: got id=%0d full=%b, expected id=0 full=0", ckpt_id, ckpt_full);
    end
    expect_rd("recover_x1", 1, 9, 0, 0);
    expect_rd("recover_x2", 2, 0, 0, 0);
    // commit landing in the recover cycle must clear the restored rename; reserve ignored
    rsv_en = 1; rsv_rd = 7; rsv_tag = 5;  step();
    ckpt_take = 1;                        step();
    commit_en = 1; commit_rd = 7; commit_tag = 5; commit_value = 32'h33;
    recover_en = 1; recover_id = 0; rsv_en = 1; rsv_rd = 8; rsv_tag = 6;
    step();
    expect_rd("recover_commit_x7", 7, 32'h33, 0, 0);
    expect_rd("recover_drops_rsv", 8, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
  endtask

  task automatic test_ring_wrap();
    logic [CW-1:0] exp_id;
    logic [2:0]    exp_cnt;
    exp_id = 0; exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      ckpt_take = 1;
      step();
      if (exp_cnt < 4) begin exp_id = exp_id + 1'b1; exp_cnt = exp_cnt + 1'b1; end
      tests++;
      if (ckpt_id !== exp_id || ckpt_full !== (exp_cnt == 4)) begin
        fails++;
        $display("[TB] FAIL ring_take%0d: got id=%0d full=%b, expected id=%0d full=%b",
                 i, ckpt_id, ckpt_full, exp_id, exp_cnt == 4);
      end
    end
    ckpt_free = 1;                  step();
    tests++;
    if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ring_free: got id=%0d full=%b, expected id=0 full=0", ckpt_id, ckpt_full);
    end
    ckpt_take = 1; ckpt_free = 1;   step();
    tests++;
    if (ckpt_id !== 2'd1 || ckpt_full !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ring_take_free: got id=%0d full=%b, expected id=1 full=0", ckpt_id, ckpt_full);
    end
    ckpt_take = 1;                  step();
    tests++;
    if (ckpt_id !== 2'd2 || ckpt_full !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ring_count_kept: got id=%0d full=%b, expected id=2 full=1", ckpt_id, ckpt_full);
    end
    // head is 2 here, so recovering slot 0 keeps slots 2 and 3
    recover_en = 1; recover_id = 0; step();
    tests++;
    if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ring_recover: got id=%0d full=%b, expected id=0 full=0", ckpt_id, ckpt_full);
    end
    ckpt_take = 1;                  step();
    tests++;
    if (ckpt_id !== 2'd1 || ckpt_full !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ring_recover_cnt3: got id=%0d full=%b, expected id=1 full=0", ckpt_id, ckpt_full);
    end
    ckpt_take = 1;                  step();
    tests++;
    if (ckpt_id !== 2'd2 || ckpt_full !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ring_recover_cnt4: got id=%0d full=%b, expected id=2 full=1", ckpt_id, ckpt_full);
    end
  endtask

  task automatic test_flush_rdy();
    rsv_en = 1; rsv_rd = 3; rsv_tag = 2; step();
    flush_all = 1; commit_en = 1; commit_rd = 4; commit_tag = 0; commit_value = 5;
    rsv_en = 1; rsv_rd = 9; rsv_tag = 1; ckpt_take = 1;
    step();
    tests++;
    if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_ptr: got id=%0d full=%b, expected id=0 full=0", ckpt_id, ckpt_full);
    end
    expect_rd("flush_x3", 3, 0, 0, 0);
    expect_rd("flush_commit_x4", 4, 5, 0, 0);
    expect_rd("flush_drops_rsv", 9, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
    ckpt_free = 1; step();
    for (int i = 0; i < 4; i++) begin
      ckpt_take = 1;
      step();
      tests++;
      if (ckpt_full !== (i == 3)) begin
        fails++;
        $display("[TB] FAIL empty_free_ignored%0d: got full=%b, expected %b", i, ckpt_full, i == 3);
      end
    end
    rdy_in = 0; flush_all = 1; ckpt_free = 1; rsv_en = 1; rsv_rd = 10; rsv_tag = 1;
    commit_en = 1; commit_rd = 11; commit_value = 32'h99;
    step();
    tests++;
    if (ckpt_id !== 2'd0 || ckpt_full !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rdy_freeze_ptr: got id=%0d full=%b, expected id=0 full=1", ckpt_id, ckpt_full);
    end
    expect_rd("rdy_freeze_rsv", 10, 0, 0, 0);
    expect_rd("rdy_freeze_commit", 11, 0, 0, 0);
    rsv_en = 1; rsv_rd = 12; rsv_tag = 3; step();
    rst_in = 1; step();
    expect_rd("midreset_x12", 12, 0, 0, 0);
    expect_rd("midreset_x4", 4, 0, 0, 0);
    tests++;
    if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_ptr: got id=%0d full=%b, expected id=0 full=0", ckpt_id, ckpt_full);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = {e.addr, e.addr};
      #1;
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
          fails++;
          $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                   e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] m_regs [8];
    logic        m_busy [8];
    logic [3:0]  m_tag  [8];
    logic [2:0]  a;
    for (int r = 0; r < 8; r++) begin m_regs[r] = 0; m_busy[r] = 0; m_tag[r] = 0; end
    for (int i = 0; i < 40; i++) begin
      rsv_en = 1'($urandom_range(0, 1)); rsv_rd = 5'($urandom_range(0, 7)); rsv_tag = 4'($urandom);
      commit_en = 1'($urandom_range(0, 1)); commit_rd = 5'($urandom_range(0, 7));
      commit_tag = $urandom_range(0, 1) ? m_tag[commit_rd[2:0]] : 4'($urandom);
      commit_value = $urandom;
      a = 3'($urandom_range(0, 7));
      if (a == 0)
        expect_rd("b2b_x0", 5'(a), 0, 0, 0);
      else if (commit_en && commit_rd[2:0] == a && m_busy[a] && m_tag[a] == commit_tag)
        expect_rd("b2b_forward", 5'(a), commit_value, 0, 0);
      else if (m_busy[a])
        expect_rd("b2b_busy", 5'(a), 0, 1, m_tag[a]);
      else
        expect_rd("b2b_value", 5'(a), m_regs[a], 0, 0);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        rd_addr = {e.addr, e.addr};
        #1;
        for (int p = 0; p < 2; p++) begin
          tests++;
          if (rd_value[p*32 +: 32] !== e.value || rd_busy[p] !== e.busy || rd_tag[p*4 +: 4] !== e.tag) begin
            fails++;
            $display("[TB] FAIL %s port%0d: got value=%h busy=%b tag=%0d, expected value=%h busy=%b tag=%0d",
                     e.name, p, rd_value[p*32 +: 32], rd_busy[p], rd_tag[p*4 +: 4], e.value, e.busy, e.tag);
          end
        end
      end
      if (commit_en && commit_rd != 0) begin
        m_regs[commit_rd[2:0]] = commit_value;
        if (m_busy[commit_rd[2:0]] && m_tag[commit_rd[2:0]] == commit_tag) m_busy[commit_rd[2:0]] = 0;
      end
      if (rsv_en && rsv_rd != 0) begin
        m_busy[rsv_rd[2:0]] = 1;
        m_tag[rsv_rd[2:0]]  = rsv_tag;
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_reserve_forward();
    test_stale_commit();
    test_ckpt_recover();
    test_ring_wrap();
    test_flush_rdy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
